// File: rtl/lvds_rx.sv
// Serial-to-parallel receiver with training-pattern word alignment (HUNT/VERIFY/LOCKED).
// Optional alignment-failure counter is enabled by defining LVDS_RX_ERR_CNT_EN.
module lvds_rx #(
    parameter int                    DATA_WIDTH    = 10,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 10'b1111100000,
    parameter int                    LOCK_COUNT    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  datain_p,
    input  logic                  datain_n,
    input  logic                  align_req,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  locked,
    output logic [7:0]            err_cnt,
    output logic [1:0]            fsm_state
);

    localparam int              PW          = $clog2(DATA_WIDTH);
    localparam logic [PW-1:0]   LAST_PHASE  = PW'(DATA_WIDTH - 1);
    localparam logic [PW-1:0]   PHASE_ONE   = PW'(1);
    localparam logic [3:0]      LOCK_TARGET = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  bit_r;
    logic [DATA_WIDTH-1:0] sr;
    logic [PW-1:0]         phase_q;
    logic [PW-1:0]         phase_d;
    logic [3:0]            match_q;
    logic [3:0]            match_d;
    logic [DATA_WIDTH-1:0] rx_data_d;
    logic                  rx_valid_d;
    logic                  err_inc;
    logic                  boundary;
    logic                  pattern_hit;

    // The complement leg carries no information once the pair is received single-ended.
    logic unused_datain_n;
    assign unused_datain_n = datain_n;

    // Input capture and MSB-first shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_r <= 1'b0;
            sr    <= '0;
        end else begin
            bit_r <= datain_p;
            sr    <= {sr[DATA_WIDTH-2:0], bit_r};
        end
    end

    // The cycle whose phase is about to wrap holds a complete word in sr.
    assign boundary    = (phase_q == LAST_PHASE);
    assign pattern_hit = (sr == TRAIN_PATTERN);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        match_d    = match_q;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        err_inc    = 1'b0;

        if (align_req) begin
            state_d = HUNT;
            phase_d = '0;
            match_d = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    phase_d = '0;
                    match_d = '0;
                    if (pattern_hit) begin
                        match_d = 4'd1;
                        state_d = (LOCK_TARGET == 4'd1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    phase_d = boundary ? '0 : phase_q + PHASE_ONE;
                    if (boundary) begin
                        if (pattern_hit) begin
                            match_d = match_q + 4'd1;
                            if (match_q + 4'd1 == LOCK_TARGET) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            state_d = HUNT;
                            phase_d = '0;
                            match_d = '0;
                            err_inc = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    phase_d = boundary ? '0 : phase_q + PHASE_ONE;
                    if (boundary) begin
                        rx_data_d  = sr;
                        rx_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    phase_d = '0;
                    match_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= HUNT;
            phase_q  <= '0;
            match_q  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            match_q  <= match_d;
            rx_data  <= rx_data_d;
            rx_valid <= rx_valid_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign fsm_state = state_q;

`ifdef LVDS_RX_ERR_CNT_EN
    logic [7:0] err_q;

    // Saturating count of VERIFY mismatches; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 8'd0;
        end else if (err_inc && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
    assign err_cnt        = 8'd0;
`endif

endmodule
